// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared types and constants for the fetch/data memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam int MEMARB_ADDR_W = 32;
    localparam int MEMARB_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/memarb_streak.sv
// ============================================================================
//  Module   : memarb_streak
//  Brief    : Counts data grants made while fetch waits; forces one fetch win
//             when the streak reaches MAX_STREAK.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memarb_streak
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_grant,
    input  logic i_grant_fetch,
    input  logic i_fetch_req,
    output logic o_fetch_override
);

    localparam int                 c_CNT_W = $clog2(MAX_STREAK + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_STREAK);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // A streak only builds while fetch is actually waiting on a data grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_grant) begin
            if (i_grant_fetch || !i_fetch_req) begin
                r_count <= '0;
            end else if (r_count != c_MAX) begin
                r_count <= r_count + c_ONE;
            end
        end
    end

    assign o_fetch_override = (r_count == c_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Single-outstanding arbiter sharing the memory-controller port
//             between instruction fetch and the data-memory stage.
//             Optional fetch starvation guard: define MEMARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEMARB_ADDR_W,
    parameter int DATA_W     = MEMARB_DATA_W,
    parameter int MAX_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_arb_en,
    input  logic [ADDR_W-1:0] if_arb_addr,
    output logic [DATA_W-1:0] arb_if_data,
    output logic              arb_if_valid,
    output logic              arb_if_stall,
    input  logic              mem_arb_read,
    input  logic              mem_arb_write,
    input  logic [ADDR_W-1:0] mem_arb_addr,
    input  logic [DATA_W-1:0] mem_arb_wdata,
    output logic [DATA_W-1:0] arb_mem_data,
    output logic              arb_mem_valid,
    output logic              arb_mem_stall,
    output logic              arb_mc_en,
    output logic              arb_mc_we,
    output logic [ADDR_W-1:0] arb_mc_addr,
    output logic [DATA_W-1:0] arb_mc_wdata,
    input  logic              mc_arb_ready,
    input  logic [DATA_W-1:0] mc_arb_data
);

    state_t r_state;
    logic   r_owner;

    logic w_mem_req;
    logic w_grant;
    logic w_pick_if;
    logic w_override;

    assign w_mem_req = mem_arb_read | mem_arb_write;
    assign w_grant   = (r_state == IDLE) && (if_arb_en || w_mem_req);
    // Data wins unless it is idle or the starvation guard hands fetch a turn.
    assign w_pick_if = if_arb_en & (~w_mem_req | w_override);

`ifdef MEMARB_STARVE_GUARD_EN
    memarb_streak #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .clock            (clock),
        .reset            (reset),
        .i_grant          (w_grant),
        .i_grant_fetch    (w_pick_if),
        .i_fetch_req      (if_arb_en),
        .o_fetch_override (w_override)
    );
`else
    assign w_override = 1'b0;
`endif

    assign arb_if_stall  = if_arb_en & ~arb_if_valid;
    assign arb_mem_stall = w_mem_req & ~arb_mem_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= OWN_IF;
            arb_mc_en     <= 1'b0;
            arb_mc_we     <= 1'b0;
            arb_mc_addr   <= '0;
            arb_mc_wdata  <= '0;
            arb_if_valid  <= 1'b0;
            arb_mem_valid <= 1'b0;
            arb_if_data   <= '0;
            arb_mem_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        arb_mc_en <= 1'b1;
                        r_state   <= BUSY;
                        if (w_pick_if) begin
                            r_owner     <= OWN_IF;
                            arb_mc_we   <= 1'b0;
                            arb_mc_addr <= if_arb_addr;
                        end else begin
                            r_owner      <= OWN_MEM;
                            arb_mc_we    <= mem_arb_write;
                            arb_mc_addr  <= mem_arb_addr;
                            arb_mc_wdata <= mem_arb_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mc_arb_ready) begin
                        arb_mc_en <= 1'b0;
                        r_state   <= RESP;
                        if (r_owner == OWN_IF) begin
                            arb_if_data  <= mc_arb_data;
                            arb_if_valid <= 1'b1;
                        end else begin
                            if (!arb_mc_we) begin
                                arb_mem_data <= mc_arb_data;
                            end
                            arb_mem_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    arb_if_valid  <= 1'b0;
                    arb_mem_valid <= 1'b0;
                    r_state       <= IDLE;
                end
                default: begin
                    arb_mc_en     <= 1'b0;
                    arb_if_valid  <= 1'b0;
                    arb_mem_valid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
